cdu_incr_pulser: RTL and testbench



---
 rtl/cdu_pkg.sv | 16 +
 rtl/cdu_req_filter.sv | 45 ++++
 rtl/cdu_incr_pulser.sv | 132 +++++++++++++
 tb/tb_cdu_incr_pulser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cdu_pkg.sv
// Shared types and sizing helpers for the CDU increment pulser.
// Pure declarations: no latency, no flow control.
package cdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } pulser_state_t;

  // Bits needed to hold the values 0..maxval inclusive.
  function automatic int unsigned cnt_w(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/cdu_req_filter.sv
// Deglitches one request level: one accept per armed high run of SETTLE samples.
// Accept is combinational in the cycle of the SETTLE-th high sample; no backpressure.
module cdu_req_filter
  import cdu_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic accept
);

  localparam int unsigned   CW      = cnt_w(SETTLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_HIT = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  always_comb begin
    accept  = armed_q && req && (cnt_q == CNT_HIT);
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!req) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (accept) armed_d = 1'b0;
    end
  end

  // Disarmed at reset so a level already high at release is ignored until it drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/cdu_incr_pulser.sv
// Turns filtered up/down count requests into single-cycle PCDU/MCDU pulses, SPACING apart.
// Pulse rises one cycle after a nonzero backlog is seen idle; no backpressure, backlog saturates into ovf.
module cdu_incr_pulser
  import cdu_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int SPACING = 8,
  parameter int PEND_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_req,
  input  logic              dn_req,
  input  logic              clr_ovf,
  output logic              pcdu,
  output logic              mcdu,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int unsigned SW = PEND_W + 2;
  localparam logic signed [SW-1:0] P_MAX = SW'((2 ** (PEND_W - 1)) - 1);
  localparam logic signed [SW-1:0] P_MIN = SW'(-(2 ** (PEND_W - 1)));

  localparam int unsigned   GW       = cnt_w(SPACING);
  localparam bit            HAS_GAP  = (SPACING > 2);
  localparam logic [GW-1:0] GAP_LOAD = HAS_GAP ? GW'(SPACING - 3) : '0;

  logic up_acc, dn_acc;

  cdu_req_filter #(.SETTLE(SETTLE)) u_up_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (up_req),
    .accept (up_acc)
  );

  cdu_req_filter #(.SETTLE(SETTLE)) u_dn_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (dn_req),
    .accept (dn_acc)
  );

  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic signed [SW-1:0]     sum;
  logic                     sat;

  // The pulse register contributes its -1/+1 during the cycle it is high.
  always_comb begin
    sum = SW'(pend_q);
    if (up_acc && !dn_acc) sum = sum + SW'(1);
    if (dn_acc && !up_acc) sum = sum - SW'(1);
    if (pcdu) sum = sum - SW'(1);
    if (mcdu) sum = sum + SW'(1);
    sat    = 1'b0;
    pend_d = sum[PEND_W-1:0];
    if (sum > P_MAX) begin
      pend_d = P_MAX[PEND_W-1:0];
      sat    = 1'b1;
    end else if (sum < P_MIN) begin
      pend_d = P_MIN[PEND_W-1:0];
      sat    = 1'b1;
    end
    ovf_d = sat | (ovf_q & ~clr_ovf);
  end

  pulser_state_t state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pcdu_q, pcdu_d, mcdu_q, mcdu_d;
  logic          pend_pos, pend_neg;

  assign pend_neg = pend_q[PEND_W-1];
  assign pend_pos = !pend_neg && (pend_q != '0);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pcdu_d  = 1'b0;
    mcdu_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_pos) begin
          state_d = EMIT;
          pcdu_d  = 1'b1;
        end else if (pend_neg) begin
          state_d = EMIT;
          mcdu_d  = 1'b1;
        end
      end
      EMIT: begin
        // IDLE and EMIT already cover two cycles of the spacing window.
        if (HAS_GAP) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pcdu_q  <= 1'b0;
      mcdu_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pcdu_q  <= pcdu_d;
      mcdu_q  <= mcdu_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pcdu    = pcdu_q;
  assign mcdu    = mcdu_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cdu_incr_pulser.sv
// Bench for cdu_incr_pulser: directed scenarios plus random request bursts
// checked every cycle against a history/timestamp reference model.
module tb_cdu_incr_pulser;

  localparam int SETTLE  = 4;
  localparam int SPACING = 8;
  localparam int PEND_W  = 4;
  localparam int PMAX    = (2 ** (PEND_W - 1)) - 1;
  localparam int PMIN    = -(2 ** (PEND_W - 1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              up_req = 1'b0;
  logic              dn_req = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              pcdu, mcdu, ovf;
  logic [PEND_W-1:0] pending;

  cdu_incr_pulser #(.SETTLE(SETTLE), .SPACING(SPACING), .PEND_W(PEND_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_req  (up_req),
    .dn_req  (dn_req),
    .clr_ovf (clr_ovf),
    .pcdu    (pcdu),
    .mcdu    (mcdu),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  string scn = "rst";

  // Reference model: run lengths since the last low sample, plus the edge index of the last pulse.
  int m_t = 0, m_last = -100, m_pend = 0;
  int run_up = 0, run_dn = 0;
  bit lo_up = 0, lo_dn = 0;
  bit m_p = 0, m_m = 0, m_ovf = 0;
  int n_acc = 0, n_drop = 0;

  int n_pc = 0, n_mc = 0, peak = 0, cyc = 0, first_rise = -1, last_rise = -1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d want %0d at %0t", scn, tag, act, exp, $time);
    end
  endtask

  function automatic int pend_s();
    return int'($signed(pending));
  endfunction

  task automatic model_reset();
    m_pend = 0; m_p = 0; m_m = 0; m_ovf = 0;
    run_up = 0; run_dn = 0; lo_up = 0; lo_dn = 0;
    m_last = m_t - SPACING;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit c);
    int au, ad, s;
    bit sat, np, nm;
    m_t++;
    au = 0; ad = 0;
    if (u) begin run_up++; au = (lo_up && run_up == SETTLE) ? 1 : 0; end
    else   begin run_up = 0; lo_up = 1; end
    if (d) begin run_dn++; ad = (lo_dn && run_dn == SETTLE) ? 1 : 0; end
    else   begin run_dn = 0; lo_dn = 1; end
    n_acc += au;
    s = m_pend + au - ad - (m_p ? 1 : 0) + (m_m ? 1 : 0);
    sat = 0;
    if (s > PMAX) begin s = PMAX; sat = 1; end
    if (s < PMIN) begin s = PMIN; sat = 1; end
    if (sat) n_drop++;
    np = 0; nm = 0;
    if ((m_t - m_last) >= SPACING && m_pend != 0) begin
      if (m_pend > 0) np = 1; else nm = 1;
      m_last = m_t;
    end
    m_pend = s;
    m_p = np;
    m_m = nm;
    m_ovf = sat | (m_ovf & !c);
  endtask

  task automatic step(input bit u, input bit d, input bit c);
    up_req = u; dn_req = d; clr_ovf = c;
    @(posedge clk);
    model_edge(u, d, c);
    #1;
    cyc++;
    chk("pcdu", pcdu, m_p);
    chk("mcdu", mcdu, m_m);
    chk("pending", pend_s(), m_pend);
    chk("ovf", ovf, m_ovf);
    if (pcdu) begin
      n_pc++;
      if (first_rise < 0) first_rise = cyc;
      last_rise = cyc;
    end
    if (mcdu) n_mc++;
    if (pend_s() > peak) peak = pend_s();
  endtask

  task automatic hold(input bit u, input bit d, input int n);
    repeat (n) step(u, d, 1'b0);
  endtask

  task automatic scn_start(input string name);
    scn = name; n_pc = 0; n_mc = 0; peak = PMIN;
    n_acc = 0; n_drop = 0; first_rise = -1; last_rise = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    chk("pcdu", pcdu, 0);
    chk("mcdu", mcdu, 0);
    chk("pending", pend_s(), 0);
    chk("ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    scn_start("s1");
    hold(0, 0, 3);
    hold(1, 0, 10);
    hold(0, 0, 20);
    chk("npc", n_pc, 1);
    chk("nmc", n_mc, 0);

    scn_start("s2");
    repeat (5) begin hold(1, 0, 3); hold(0, 0, 1); end
    hold(0, 0, 10);
    chk("npc", n_pc, 0);

    scn_start("s3");
    repeat (6) begin hold(1, 0, 4); hold(0, 0, 1); end
    hold(0, 0, 60);
    chk("npc", n_pc, 6);
    chk("span", last_rise - first_rise, 5 * SPACING);
    chk("end_pend", pend_s(), 0);

    scn_start("s4");
    hold(0, 0, 2);
    hold(1, 1, 6);
    hold(0, 0, 15);
    chk("npc", n_pc, 0);
    chk("nmc", n_mc, 0);

    scn_start("s5");
    repeat (30) begin hold(1, 0, 4); hold(0, 0, 1); end
    chk("peak", peak, PMAX);
    chk("ovf_set", ovf, 1);
    hold(0, 0, 120);
    chk("ovf_sticky", ovf, 1);
    step(0, 0, 1);
    chk("ovf_clr", ovf, 0);
    chk("npc_vs_acc", n_pc, n_acc - n_drop);

    scn_start("s6");
    repeat (8) begin hold(1, 0, 4); hold(0, 0, 1); end
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pcdu", pcdu, 0);
    chk("rst_mcdu", mcdu, 0);
    chk("rst_pend", pend_s(), 0);
    chk("rst_ovf", ovf, 0);
    model_reset();
    up_req = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n_pc = 0;
    hold(1, 0, 20);
    chk("npc_held", n_pc, 0);
    hold(0, 0, 1);
    hold(1, 0, 6);
    hold(0, 0, 15);
    chk("npc_rearm", n_pc, 1);

    scn_start("rnd");
    repeat (300) begin
      int mode, hl, ll;
      mode = $urandom_range(0, 4);
      hl = $urandom_range(1, 8);
      ll = $urandom_range(1, 3);
      for (int i = 0; i < hl; i++) begin
        bit u, d, c;
        c = ($urandom_range(0, 15) == 0);
        case (mode)
          0: begin u = 1; d = 0; end
          1: begin u = 0; d = 1; end
          2: begin u = 1; d = 1; end
          3: begin u = 0; d = 1; end
          default: begin u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
        endcase
        step(u, d, c);
      end
      for (int i = 0; i < ll; i++) step(0, 0, 1'($urandom_range(0, 7) == 0));
    end
    hold(0, 0, 150);
    chk("drain_pend", pend_s(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
